fp_rob_buffer: RTL and testbench

// - Floating-point reorder buffer: the ROB-side counterpart of fp_regstat.
// - Allocates ROB indices at issue, captures results from the CDB, and serves operand

---
 rtl/fp_rob_buffer.sv | 146 ++++++++++++++
 tb/tb_fp_rob_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rob_buffer.sv
// Floating-point reorder buffer: allocates ROB slots at issue, captures CDB results,
// serves operand reads with same-cycle CDB bypass, and drives the in-order commit stream.
module fp_rob_buffer #(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 64,
  parameter int REG_NUM = 32,
  localparam int RegIdxLen = $clog2(REG_NUM),
  localparam int RobIdxLen = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [RegIdxLen-1:0] issue_rd_idx_i,
  output logic [RobIdxLen-1:0] issue_rob_idx_o,
  input  logic                 cdb_valid_i,
  input  logic [RobIdxLen-1:0] cdb_rob_idx_i,
  input  logic [XLEN-1:0]      cdb_value_i,
  input  logic [RobIdxLen-1:0] op1_rob_idx_i,
  output logic                 op1_ready_o,
  output logic [XLEN-1:0]      op1_value_o,
  input  logic [RobIdxLen-1:0] op2_rob_idx_i,
  output logic                 op2_ready_o,
  output logic [XLEN-1:0]      op2_value_o,
  input  logic [RobIdxLen-1:0] op3_rob_idx_i,
  output logic                 op3_ready_o,
  output logic [XLEN-1:0]      op3_value_o,
  output logic                 comm_valid_o,
  input  logic                 comm_ready_i,
  output logic [RegIdxLen-1:0] comm_rd_idx_o,
  output logic [RobIdxLen-1:0] comm_rob_idx_o,
  output logic [XLEN-1:0]      comm_value_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_e;

  localparam logic [RobIdxLen:0] PtrOne = (RobIdxLen+1)'(1);

  entry_state_e         r_state [DEPTH];
  logic [RegIdxLen-1:0] r_rd    [DEPTH];
  logic [XLEN-1:0]      r_value [DEPTH];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [RobIdxLen:0]   r_head;
  logic [RobIdxLen:0]   r_tail;

  logic [RobIdxLen-1:0] w_head_idx;
  logic [RobIdxLen-1:0] w_tail_idx;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_issue_fire;
  logic                 w_cdb_fire;
  logic                 w_comm_valid;
  logic                 w_comm_fire;

  assign w_head_idx   = r_head[RobIdxLen-1:0];
  assign w_tail_idx   = r_tail[RobIdxLen-1:0];
  assign w_empty      = (r_head == r_tail);
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[RobIdxLen] != r_tail[RobIdxLen]);
  assign w_issue_fire = issue_valid_i && !w_full;
  assign w_cdb_fire   = cdb_valid_i && (r_state[cdb_rob_idx_i] == ST_PENDING);
  assign w_comm_valid = !w_empty && (r_state[w_head_idx] == ST_DONE);
  assign w_comm_fire  = w_comm_valid && comm_ready_i;

  // Issue, CDB and commit only ever target EMPTY, PENDING and DONE entries respectively,
  // so the three updates never collide on one slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_EMPTY;
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_EMPTY;
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_issue_fire) begin
        r_state[w_tail_idx] <= ST_PENDING;
        r_rd[w_tail_idx]    <= issue_rd_idx_i;
        r_tail              <= r_tail + PtrOne;
      end
      if (w_cdb_fire) begin
        r_state[cdb_rob_idx_i] <= ST_DONE;
        r_value[cdb_rob_idx_i] <= cdb_value_i;
      end
      if (w_comm_fire) begin
        r_state[w_head_idx] <= ST_EMPTY;
        r_head              <= r_head + PtrOne;
      end
    end
  end

  logic [RobIdxLen-1:0] w_op_idx   [3];
  logic [2:0]           w_op_ready;
  logic [XLEN-1:0]      w_op_value [3];

  assign w_op_idx[0] = op1_rob_idx_i;
  assign w_op_idx[1] = op2_rob_idx_i;
  assign w_op_idx[2] = op3_rob_idx_i;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_op
      logic w_done;
      logic w_bypass;
      assign w_done   = (r_state[w_op_idx[gi]] == ST_DONE);
      assign w_bypass = cdb_valid_i && (cdb_rob_idx_i == w_op_idx[gi])
                        && (r_state[w_op_idx[gi]] == ST_PENDING);
      assign w_op_ready[gi] = w_done || w_bypass;
      assign w_op_value[gi] = w_done ? r_value[w_op_idx[gi]] :
                              (w_bypass ? cdb_value_i : '0);
    end
  endgenerate

  assign op1_ready_o = w_op_ready[0];
  assign op1_value_o = w_op_value[0];
  assign op2_ready_o = w_op_ready[1];
  assign op2_value_o = w_op_value[1];
  assign op3_ready_o = w_op_ready[2];
  assign op3_value_o = w_op_value[2];

  assign issue_ready_o   = !w_full;
  assign issue_rob_idx_o = w_tail_idx;
  assign comm_valid_o    = w_comm_valid;
  assign comm_rd_idx_o   = r_rd[w_head_idx];
  assign comm_rob_idx_o  = w_head_idx;
  assign comm_value_o    = r_value[w_head_idx];

`ifndef SYNTHESIS
  // A broadcast to an entry that is not waiting for a result indicates an upstream bug.
  a_cdb_target_pending: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    cdb_valid_i |-> (r_state[cdb_rob_idx_i] == ST_PENDING));
`endif

endmodule

// File: tb/tb_fp_rob_buffer.sv
// Scoreboard bench for fp_rob_buffer: directed stimulus queues expected issue indices and
// commits; a negedge monitor pops and compares on every handshake.
module tb_fp_rob_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [4:0]  issue_rd_idx_i = '0;
  logic [2:0]  issue_rob_idx_o;
  logic        cdb_valid_i = 1'b0;
  logic [2:0]  cdb_rob_idx_i = '0;
  logic [63:0] cdb_value_i = '0;
  logic [2:0]  op1_rob_idx_i = '0;
  logic        op1_ready_o;
  logic [63:0] op1_value_o;
  logic [2:0]  op2_rob_idx_i = '0;
  logic        op2_ready_o;
  logic [63:0] op2_value_o;
  logic [2:0]  op3_rob_idx_i = '0;
  logic        op3_ready_o;
  logic [63:0] op3_value_o;
  logic        comm_valid_o;
  logic        comm_ready_i = 1'b0;
  logic [4:0]  comm_rd_idx_o;
  logic [2:0]  comm_rob_idx_o;
  logic [63:0] comm_value_o;

  fp_rob_buffer #(.DEPTH(8), .XLEN(64), .REG_NUM(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_rob_idx_o(issue_rob_idx_o),
    .cdb_valid_i(cdb_valid_i), .cdb_rob_idx_i(cdb_rob_idx_i), .cdb_value_i(cdb_value_i),
    .op1_rob_idx_i(op1_rob_idx_i), .op1_ready_o(op1_ready_o), .op1_value_o(op1_value_o),
    .op2_rob_idx_i(op2_rob_idx_i), .op2_ready_o(op2_ready_o), .op2_value_o(op2_value_o),
    .op3_rob_idx_i(op3_rob_idx_i), .op3_ready_o(op3_ready_o), .op3_value_o(op3_value_o),
    .comm_valid_o(comm_valid_o), .comm_ready_i(comm_ready_i),
    .comm_rd_idx_o(comm_rd_idx_o), .comm_rob_idx_o(comm_rob_idx_o),
    .comm_value_o(comm_value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  idx;
    logic [63:0] val;
  } exp_commit_t;

  logic [2:0]  issue_q[$];
  exp_commit_t commit_q[$];
  int n_pass = 0;
  int n_total = 0;

  localparam logic [63:0] V0 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] V1 = 64'hC000_0000_0000_0000;
  localparam logic [63:0] V2 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] VB = 64'h4000_0000_0000_0000;
  localparam logic [63:0] V4 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] V5 = 64'h4014_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-22s got %h want %h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: handshakes cancelled by flush or made during reset are not transactions.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && !flush_i) begin
        if (issue_valid_i && issue_ready_o) begin
          if (issue_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_issue: got rob_idx %0d want no handshake", issue_rob_idx_o);
          end else begin
            chk("issue_rob_idx", 64'(issue_rob_idx_o), 64'(issue_q.pop_front()));
          end
        end
        if (comm_valid_o && comm_ready_i) begin
          if (commit_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_commit: got rob_idx %0d want no commit", comm_rob_idx_o);
          end else begin
            exp_commit_t e;
            e = commit_q.pop_front();
            chk("commit_rob_idx", 64'(comm_rob_idx_o), 64'(e.idx));
            chk("commit_rd_idx", 64'(comm_rd_idx_o), 64'(e.rd));
            chk("commit_value", comm_value_o, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_issue_rob_idx", 64'(issue_rob_idx_o), 64'd0);
    chk("rst_comm_valid", 64'(comm_valid_o), 64'd0);
    chk("rst_comm_rob_idx", 64'(comm_rob_idx_o), 64'd0);
    chk("rst_comm_rd_idx", 64'(comm_rd_idx_o), 64'd0);
    chk("rst_comm_value", comm_value_o, 64'd0);
    chk("rst_op_ready", 64'({op1_ready_o, op2_ready_o, op3_ready_o}), 64'd0);
    step();

    // Fill all eight slots, then a ninth request must stall.
    for (int i = 0; i < 8; i++) begin
      issue_valid_i = 1'b1;
      issue_rd_idx_i = 5'(i + 1);
      issue_q.push_back(3'(i));
      step();
    end
    issue_rd_idx_i = 5'd9;
    @(negedge clk_i);
    chk("full_issue_ready", 64'(issue_ready_o), 64'd0);
    step();
    issue_valid_i = 1'b0;

    // Out-of-order completion: only the head may commit.
    cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd2; cdb_value_i = V2;
    @(negedge clk_i);
    chk("idx2_done_no_commit", 64'(comm_valid_o), 64'd0);
    step();
    cdb_rob_idx_i = 3'd0; cdb_value_i = V0;
    @(negedge clk_i);
    chk("cdb_head_same_cycle", 64'(comm_valid_o), 64'd0);
    step();
    cdb_valid_i = 1'b0;

    // Full with head DONE: commit pops, simultaneous issue is held off one cycle.
    comm_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9;
    commit_q.push_back('{rd: 5'd1, idx: 3'd0, val: V0});
    @(negedge clk_i);
    chk("head_valid", 64'(comm_valid_o), 64'd1);
    chk("full_commit_issue_rdy", 64'(issue_ready_o), 64'd0);
    step();
    comm_ready_i = 1'b0;
    issue_q.push_back(3'd0);
    @(negedge clk_i);
    chk("after_pop_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("head1_not_done", 64'(comm_valid_o), 64'd0);
    chk("head_moved_to_1", 64'(comm_rob_idx_o), 64'd1);
    step();
    issue_valid_i = 1'b0;

    // Same-cycle bypass on op1, stored value on op2, pending on op3.
    cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd3; cdb_value_i = VB;
    op1_rob_idx_i = 3'd3; op2_rob_idx_i = 3'd2; op3_rob_idx_i = 3'd4;
    @(negedge clk_i);
    chk("op1_bypass_ready", 64'(op1_ready_o), 64'd1);
    chk("op1_bypass_value", op1_value_o, VB);
    chk("op2_done_ready", 64'(op2_ready_o), 64'd1);
    chk("op2_done_value", op2_value_o, V2);
    chk("op3_pending_ready", 64'(op3_ready_o), 64'd0);
    chk("op3_pending_value", op3_value_o, 64'd0);
    step();

    // CDB in cycle t makes the head committable in t+1.
    cdb_rob_idx_i = 3'd1; cdb_value_i = V1;
    @(negedge clk_i);
    chk("latency_t", 64'(comm_valid_o), 64'd0);
    step();
    cdb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("latency_t_plus_1", 64'(comm_valid_o), 64'd1);
    step();
    comm_ready_i = 1'b1;
    commit_q.push_back('{rd: 5'd2, idx: 3'd1, val: V1});
    commit_q.push_back('{rd: 5'd3, idx: 3'd2, val: V2});
    commit_q.push_back('{rd: 5'd4, idx: 3'd3, val: VB});
    step(); step(); step();
    comm_ready_i = 1'b0;
    @(negedge clk_i);
    chk("head4_pending", 64'(comm_valid_o), 64'd0);
    chk("head_at_4", 64'(comm_rob_idx_o), 64'd4);
    step();

    // Flush beats issue, CDB and commit in the same cycle.
    cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd4; cdb_value_i = V4;
    step();
    cdb_rob_idx_i = 3'd5; cdb_value_i = V5;
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_rd_idx_i = 5'd20; comm_ready_i = 1'b1;
    @(negedge clk_i);
    chk("pre_flush_head_valid", 64'(comm_valid_o), 64'd1);
    step();
    flush_i = 1'b0; issue_valid_i = 1'b0; cdb_valid_i = 1'b0; comm_ready_i = 1'b0;
    op1_rob_idx_i = 3'd0; op2_rob_idx_i = 3'd4; op3_rob_idx_i = 3'd5;
    @(negedge clk_i);
    chk("flush_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("flush_issue_rob_idx", 64'(issue_rob_idx_o), 64'd0);
    chk("flush_comm_valid", 64'(comm_valid_o), 64'd0);
    chk("flush_comm_rob_idx", 64'(comm_rob_idx_o), 64'd0);
    chk("flush_comm_value", comm_value_o, 64'd0);
    chk("flush_op_ready", 64'({op1_ready_o, op2_ready_o, op3_ready_o}), 64'd0);
    step();

    // Asynchronous reset with five entries in flight, head already DONE.
    for (int i = 0; i < 5; i++) begin
      issue_valid_i = 1'b1;
      issue_rd_idx_i = 5'(i + 1);
      issue_q.push_back(3'(i));
      step();
    end
    issue_valid_i = 1'b0;
    cdb_valid_i = 1'b1; cdb_rob_idx_i = 3'd0; cdb_value_i = V0;
    step();
    cdb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_reset_head_valid", 64'(comm_valid_o), 64'd1);
    step();
    rst_ni = 1'b0;
    comm_ready_i = 1'b1;
    #1;
    chk("async_rst_comm_valid", 64'(comm_valid_o), 64'd0);
    chk("async_rst_issue_idx", 64'(issue_rob_idx_o), 64'd0);
    chk("async_rst_comm_rd", 64'(comm_rd_idx_o), 64'd0);
    chk("async_rst_op1_ready", 64'(op1_ready_o), 64'd0);
    step(); step();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("post_rst_no_commit", 64'(comm_valid_o), 64'd0);
    end
    comm_ready_i = 1'b0;
    step();

    chk("issue_q_drained", 64'(issue_q.size()), 64'd0);
    chk("commit_q_drained", 64'(commit_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
